// File: rtl/alu4_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu4_seq_pkg
// Brief    : Opcodes, FSM states and ALU control mapping for alu4_sequencer.
// Revision : 1.0
// ============================================================================
package alu4_seq_pkg;

   localparam logic [2:0] OP_NAND = 3'd0;
   localparam logic [2:0] OP_ADD  = 3'd1;
   localparam logic [2:0] OP_SUB  = 3'd2;
   localparam logic [2:0] OP_MUL  = 3'd3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_EXEC     = 2'd1,
      ST_MUL_ITER = 2'd2,
      ST_RESP     = 2'd3
   } state_t;

   // op_code0 selects the adder, op_code1 turns it into a subtractor
   typedef struct packed {
      logic op_code1;
      logic op_code0;
   } alu_ctrl_t;

   function automatic alu_ctrl_t alu_ctrl(input logic [2:0] op);
      alu_ctrl_t c;
      c.op_code0 = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
      c.op_code1 = (op == OP_SUB);
      return c;
   endfunction

   function automatic logic op_legal(input logic [2:0] op);
      return op <= OP_MUL;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu4_core.sv
`default_nettype none
// ============================================================================
// Module   : alu4_core
// Brief    : Combinational 4-bit NAND / ripple add / ripple subtract.
// Revision : 1.0
// ============================================================================
module alu4_core
   import alu4_seq_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       op_code0,
   input  logic       op_code1,
   output logic [3:0] result,
   output logic       carry_out
);

   always_comb begin : p_alu
      logic [4:0] c;
      logic [3:0] bx;
      logic [3:0] sum;
      bx   = b ^ {4{op_code1}};
      c    = '0;
      sum  = '0;
      c[0] = op_code1;
      for (int i = 0; i < 4; i++) begin
         sum[i]   = a[i] ^ bx[i] ^ c[i];
         c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
      end
      if (op_code0) begin
         result    = sum;
         carry_out = c[4];
      end else begin
         result    = ~(a & b);
         carry_out = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu4_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu4_sequencer
// Brief    : Multi-cycle command sequencer around alu4_core with accumulator
//            and shift-add multiply.
// Revision : 1.0
// ============================================================================
module alu4_sequencer
   import alu4_seq_pkg::*;
#(
   parameter int MUL_STEPS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   input  logic       cmd_use_acc,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [3:0] rsp_result,
   output logic       rsp_zero,
   output logic       rsp_carry,
   output logic       rsp_err,
   output logic       busy
);

   localparam logic [1:0] LAST_STEP = 2'(MUL_STEPS - 1);

   state_t     state_q;
   logic [2:0] op_q;
   logic [3:0] a_q, b_q, acc_q, partial_q, res_q;
   logic [1:0] step_q;
   logic       ovf_q, zero_q, carry_q, err_q;
   logic       rsp_valid_q, cmd_ready_q, busy_q;

   logic       w_mul;
   alu_ctrl_t  w_ctrl;
   logic [3:0] w_core_a, w_core_b, w_core_res, w_shift_a, w_lost;
   logic       w_core_carry, w_take;
   logic [3:0] partial_d;
   logic       ovf_d;

   // During MUL the shared core adds the shifted multiplicand into the partial
   assign w_mul     = (state_q == ST_MUL_ITER);
   assign w_ctrl    = w_mul ? alu_ctrl(OP_ADD) : alu_ctrl(op_q);
   assign w_shift_a = a_q << step_q;
   assign w_lost    = a_q >> (3'd4 - {1'b0, step_q});
   assign w_take    = b_q[step_q];
   assign w_core_a  = w_mul ? partial_q : a_q;
   assign w_core_b  = w_mul ? w_shift_a : b_q;

   alu4_core u_core (
      .a         (w_core_a),
      .b         (w_core_b),
      .op_code0  (w_ctrl.op_code0),
      .op_code1  (w_ctrl.op_code1),
      .result    (w_core_res),
      .carry_out (w_core_carry)
   );

   assign partial_d = w_take ? w_core_res : partial_q;
   assign ovf_d     = ovf_q | (w_take & (w_core_carry | (w_lost != 4'd0)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         partial_q   <= '0;
         step_q      <= '0;
         ovf_q       <= 1'b0;
         res_q       <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  op_q        <= cmd_op;
                  a_q         <= cmd_use_acc ? acc_q : cmd_a;
                  b_q         <= cmd_b;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (!op_legal(cmd_op)) begin
                     res_q       <= '0;
                     zero_q      <= 1'b1;
                     carry_q     <= 1'b0;
                     err_q       <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state_q     <= ST_RESP;
                  end else if (cmd_op == OP_MUL) begin
                     partial_q <= '0;
                     step_q    <= '0;
                     ovf_q     <= 1'b0;
                     state_q   <= ST_MUL_ITER;
                  end else begin
                     state_q <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               res_q       <= w_core_res;
               zero_q      <= (w_core_res == 4'd0);
               carry_q     <= w_core_carry;
               err_q       <= 1'b0;
               acc_q       <= w_core_res;
               rsp_valid_q <= 1'b1;
               state_q     <= ST_RESP;
            end
            ST_MUL_ITER: begin
               partial_q <= partial_d;
               ovf_q     <= ovf_d;
               step_q    <= step_q + 2'd1;
               if (step_q == LAST_STEP) begin
                  res_q       <= partial_d;
                  zero_q      <= (partial_d == 4'd0);
                  carry_q     <= ovf_d;
                  err_q       <= 1'b0;
                  acc_q       <= partial_d;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = res_q;
   assign rsp_zero   = zero_q;
   assign rsp_carry  = carry_q;
   assign rsp_err    = err_q;
   assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_alu4_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu4_sequencer
// Brief    : Directed self-checking bench for alu4_sequencer.
// Revision : 1.0
// ============================================================================
module tb_alu4_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = '0;
   logic [3:0] cmd_a = '0;
   logic [3:0] cmd_b = '0;
   logic       cmd_use_acc = 1'b0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [3:0] rsp_result;
   logic       rsp_zero, rsp_carry, rsp_err, busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu4_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .cmd_use_acc (cmd_use_acc),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_zero    (rsp_zero),
      .rsp_carry   (rsp_carry),
      .rsp_err     (rsp_err),
      .busy        (busy)
   );

   // Leaves the bench 1ns after the accept edge
   task automatic do_accept(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                            input logic use_acc);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc;
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_use_acc = 1'b0;
   endtask

   // lat = index (relative to accept edge) of the first edge that samples rsp_valid high
   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic do_handshake();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
      n_cmp++; if ({rsp_result, rsp_zero, rsp_carry, rsp_err} !== 7'b0) begin n_bad++;
         $display("FAIL rst_rsp_fields got %h/%b%b%b want 0/000", rsp_result, rsp_zero, rsp_carry, rsp_err); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_exec_ops();
      logic [2:0] ops [5] = '{3'd1, 3'd2, 3'd2, 3'd0, 3'd0};
      logic [3:0] as  [5] = '{4'h7, 4'h3, 4'h5, 4'hF, 4'h5};
      logic [3:0] bs  [5] = '{4'h9, 4'h5, 4'h3, 4'hF, 4'h3};
      logic [3:0] er  [5] = '{4'h0, 4'hE, 4'h2, 4'h0, 4'hE};
      logic       ez  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic       ec  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      int lat;
      for (int i = 0; i < 5; i++) begin
         do_accept(ops[i], as[i], bs[i], 1'b0);
         n_cmp++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin n_bad++;
            $display("FAIL exec%0d_busy got busy=%b ready=%b want 1/0", i, busy, cmd_ready); end
         wait_rsp(lat);
         n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL exec%0d_latency got %0d want 2", i, lat); end
         n_cmp++; if ({rsp_result, rsp_zero, rsp_carry, rsp_err} !== {er[i], ez[i], ec[i], 1'b0}) begin n_bad++;
            $display("FAIL exec%0d_rsp got %h z%b c%b e%b want %h z%b c%b e0", i,
                     rsp_result, rsp_zero, rsp_carry, rsp_err, er[i], ez[i], ec[i]); end
         do_handshake();
         n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_bad++;
            $display("FAIL exec%0d_drop got valid=%b ready=%b want 0/1", i, rsp_valid, cmd_ready); end
      end
   endtask

   task automatic test_mul();
      logic [3:0] as [3] = '{4'h3, 4'h4, 4'h2};
      logic [3:0] bs [3] = '{4'h5, 4'h4, 4'h6};
      logic [3:0] er [3] = '{4'hF, 4'h0, 4'hC};
      logic       ez [3] = '{1'b0, 1'b1, 1'b0};
      logic       ec [3] = '{1'b0, 1'b1, 1'b0};
      int lat;
      for (int i = 0; i < 3; i++) begin
         do_accept(3'd3, as[i], bs[i], 1'b0);
         wait_rsp(lat);
         n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL mul%0d_latency got %0d want 5", i, lat); end
         n_cmp++; if ({rsp_result, rsp_zero, rsp_carry, rsp_err} !== {er[i], ez[i], ec[i], 1'b0}) begin n_bad++;
            $display("FAIL mul%0d_rsp got %h z%b c%b e%b want %h z%b c%b e0", i,
                     rsp_result, rsp_zero, rsp_carry, rsp_err, er[i], ez[i], ec[i]); end
         do_handshake();
      end
   endtask

   task automatic test_chain_illegal();
      int lat;
      do_accept(3'd1, 4'h2, 4'h3, 1'b0);
      wait_rsp(lat);
      do_handshake();
      do_accept(3'd1, 4'hF, 4'h4, 1'b1);
      wait_rsp(lat);
      n_cmp++; if (rsp_result !== 4'h9 || rsp_carry !== 1'b0) begin n_bad++;
         $display("FAIL chain_acc_add got %h c%b want 9 c0", rsp_result, rsp_carry); end
      do_handshake();
      do_accept(3'd6, 4'h1, 4'h1, 1'b0);
      wait_rsp(lat);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL illegal_latency got %0d want 1", lat); end
      n_cmp++; if ({rsp_result, rsp_zero, rsp_carry, rsp_err} !== {4'h0, 1'b1, 1'b0, 1'b1}) begin n_bad++;
         $display("FAIL illegal_rsp got %h z%b c%b e%b want 0 z1 c0 e1", rsp_result, rsp_zero, rsp_carry, rsp_err); end
      do_handshake();
      do_accept(3'd1, 4'h0, 4'h0, 1'b1);
      wait_rsp(lat);
      n_cmp++; if (rsp_result !== 4'h9 || rsp_err !== 1'b0) begin n_bad++;
         $display("FAIL illegal_keeps_acc got %h e%b want 9 e0", rsp_result, rsp_err); end
      do_handshake();
   endtask

   task automatic test_backpressure();
      int lat;
      do_accept(3'd1, 4'h1, 4'h1, 1'b0);
      wait_rsp(lat);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_cmp++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_result !== 4'h2 || rsp_zero !== 1'b0)
         begin n_bad++;
            $display("FAIL bp_hold%0d got v%b r%b res %h z%b want v1 r0 res 2 z0", i,
                     rsp_valid, cmd_ready, rsp_result, rsp_zero); end
      end
      do_handshake();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drop got %b want 0", rsp_valid); end
      rsp_ready = 1'b1;
      do_accept(3'd2, 4'h9, 4'h4, 1'b0);
      wait_rsp(lat);
      n_cmp++; if (lat !== 2 || rsp_result !== 4'h5 || rsp_carry !== 1'b1) begin n_bad++;
         $display("FAIL early_ready_rsp got lat %0d res %h c%b want 2 5 c1", lat, rsp_result, rsp_carry); end
      @(posedge clk); #1;
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL early_ready_drop got %b want 0", rsp_valid); end
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_mul();
      int lat;
      do_accept(3'd1, 4'h6, 4'h1, 1'b0);
      wait_rsp(lat);
      do_handshake();
      do_accept(3'd3, 4'h7, 4'h7, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({busy, cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_err} !== 10'b01_0_0000_000)
      begin n_bad++;
         $display("FAIL midrst_outputs got busy%b rdy%b v%b %h z%b c%b e%b want busy0 rdy1 v0 0 z0 c0 e0",
                  busy, cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_err); end
      @(negedge clk); rst_n = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_no_rsp got %b want 0", rsp_valid); end
      end
      do_accept(3'd1, 4'hF, 4'h3, 1'b1);
      wait_rsp(lat);
      n_cmp++; if (lat !== 2 || rsp_result !== 4'h3) begin n_bad++;
         $display("FAIL midrst_acc_cleared got lat %0d res %h want 2 3", lat, rsp_result); end
      do_handshake();
   endtask

   initial begin
      test_reset();
      test_exec_ops();
      test_mul();
      test_chain_illegal();
      test_backpressure();
      test_reset_mid_mul();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
